// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: sends a full frame (leader, 32 data bits LSB-first, stop mark) or a repeat code.
// Drives a carrier-modulated output for the LED driver and an unmodulated envelope for receiver loopback.
module ir_nec_tx #(
  parameter int unsigned UNIT_CYCLES  = 6750,
  parameter int unsigned CARRIER_HALF = 158
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       repeat_req,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       ir_env,
  output logic       ir_out
);

  localparam int unsigned CYCW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int unsigned CARW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CYCW-1:0]   r_cyc, w_cyc_nxt;
  logic [4:0]        r_units, w_units_nxt;
  logic [CARW-1:0]   r_car, w_car_nxt;
  logic              r_phase, w_phase_nxt;
  logic [31:0]       r_shift, w_shift_nxt;
  logic [5:0]        r_bits, w_bits_nxt;
  logic              r_rep, w_rep_nxt;
  logic              w_done_nxt;
  logic              w_mark_nxt;
  logic              w_unit_end;
  logic              w_state_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_units <= '0;
      r_car   <= '0;
      r_phase <= 1'b0;
      r_shift <= '0;
      r_bits  <= '0;
      r_rep   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ir_env  <= 1'b0;
      ir_out  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_units <= w_units_nxt;
      r_car   <= w_car_nxt;
      r_phase <= w_phase_nxt;
      r_shift <= w_shift_nxt;
      r_bits  <= w_bits_nxt;
      r_rep   <= w_rep_nxt;
      busy    <= (w_state_nxt != S_IDLE);
      done    <= w_done_nxt;
      ir_env  <= w_mark_nxt;
      ir_out  <= w_mark_nxt & w_phase_nxt;
    end
  end

  // Outputs are registered from next-state values so they align with the state they describe.
  always_comb begin
    w_state_nxt = r_state;
    w_unit_end  = (r_cyc == CYCW'(UNIT_CYCLES - 1));
    w_state_end = w_unit_end && (r_units == 5'd1);
    w_cyc_nxt   = w_unit_end ? '0 : r_cyc + CYCW'(1);
    w_units_nxt = w_unit_end ? r_units - 5'd1 : r_units;
    w_shift_nxt = r_shift;
    w_bits_nxt  = r_bits;
    w_rep_nxt   = r_rep;
    w_done_nxt  = 1'b0;
    w_car_nxt   = '0;
    w_phase_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cyc_nxt   = '0;
        w_units_nxt = '0;
        if (start) begin
          w_shift_nxt = {~cmd, cmd, ~addr, addr};
          w_bits_nxt  = 6'd32;
          w_rep_nxt   = 1'b0;
          w_units_nxt = 5'd16;
          w_state_nxt = S_LEAD_MARK;
        end else if (repeat_req) begin
          w_bits_nxt  = 6'd0;
          w_rep_nxt   = 1'b1;
          w_units_nxt = 5'd16;
          w_state_nxt = S_LEAD_MARK;
        end
      end
      S_LEAD_MARK: begin
        if (w_state_end) begin
          w_units_nxt = r_rep ? 5'd4 : 5'd8;
          w_state_nxt = S_LEAD_SPACE;
        end
      end
      S_LEAD_SPACE: begin
        if (w_state_end) begin
          w_units_nxt = 5'd1;
          w_state_nxt = (r_bits != 6'd0) ? S_BIT_MARK : S_STOP_MARK;
        end
      end
      S_BIT_MARK: begin
        if (w_state_end) begin
          w_units_nxt = r_shift[0] ? 5'd3 : 5'd1;
          w_state_nxt = S_BIT_SPACE;
        end
      end
      S_BIT_SPACE: begin
        if (w_state_end) begin
          w_shift_nxt = {1'b0, r_shift[31:1]};
          w_bits_nxt  = r_bits - 6'd1;
          w_units_nxt = 5'd1;
          w_state_nxt = (r_bits != 6'd1) ? S_BIT_MARK : S_STOP_MARK;
        end
      end
      S_STOP_MARK: begin
        if (w_state_end) begin
          w_units_nxt = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_mark_nxt = (w_state_nxt == S_LEAD_MARK) || (w_state_nxt == S_BIT_MARK) ||
                 (w_state_nxt == S_STOP_MARK);

    // Carrier restarts in the high phase on the first cycle of every mark.
    if (w_mark_nxt && (w_state_nxt != r_state)) begin
      w_car_nxt   = '0;
      w_phase_nxt = 1'b1;
    end else if (w_mark_nxt) begin
      if (r_car == CARW'(CARRIER_HALF - 1)) begin
        w_car_nxt   = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_car_nxt   = r_car + CARW'(1);
        w_phase_nxt = r_phase;
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Self-checking bench for ir_nec_tx: two instances (4/1 and 8/2 timing) compared cycle by cycle
// against a segment-list model of the NEC waveform built from address/command.
module tb_ir_nec_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_start, a_rep, a_busy, a_done, a_env, a_out;
  logic [7:0] a_addr, a_cmd;
  logic       b_start, b_rep, b_busy, b_done, b_env, b_out;
  logic [7:0] b_addr, b_cmd;

  ir_nec_tx #(.UNIT_CYCLES(4), .CARRIER_HALF(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .repeat_req(a_rep), .addr(a_addr), .cmd(a_cmd),
    .busy(a_busy), .done(a_done), .ir_env(a_env), .ir_out(a_out));

  ir_nec_tx #(.UNIT_CYCLES(8), .CARRIER_HALF(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .repeat_req(b_rep), .addr(b_addr), .cmd(b_cmd),
    .busy(b_busy), .done(b_done), .ir_env(b_env), .ir_out(b_out));

  int checks = 0;
  int failures = 0;

  bit m_env [0:1099];
  bit m_out [0:1099];
  bit cap   [0:1099];
  int m_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unit_of(input int sel);
    return (sel != 0) ? 8 : 4;
  endfunction

  function automatic int half_of(input int sel);
    return (sel != 0) ? 2 : 1;
  endfunction

  task automatic add_seg(input bit lvl, input int units, input int u, input int ch);
    for (int p = 0; p < units * u; p++) begin
      m_env[m_len] = lvl;
      m_out[m_len] = lvl && (((p / ch) % 2) == 0);
      m_len++;
    end
  endtask

  // Waveform as a list of (level, units) segments, expanded to one bit per clock.
  task automatic build(input int sel, input bit rep, input logic [7:0] a, input logic [7:0] c);
    logic [31:0] word;
    int u, ch;
    u = unit_of(sel);
    ch = half_of(sel);
    word = {~c, c, ~a, a};
    m_len = 0;
    add_seg(1'b1, 16, u, ch);
    add_seg(1'b0, rep ? 4 : 8, u, ch);
    if (!rep) begin
      for (int i = 0; i < 32; i++) begin
        add_seg(1'b1, 1, u, ch);
        add_seg(1'b0, word[i] ? 3 : 1, u, ch);
      end
    end
    add_seg(1'b1, 1, u, ch);
  endtask

  task automatic drive(input int sel, input logic st, input logic rp, input logic [7:0] ad,
                       input logic [7:0] cm);
    if (sel != 0) begin
      b_start = st; b_rep = rp; b_addr = ad; b_cmd = cm;
    end else begin
      a_start = st; a_rep = rp; a_addr = ad; a_cmd = cm;
    end
  endtask

  task automatic launch(input int sel, input logic st, input logic rp, input logic [7:0] ad,
                        input logic [7:0] cm);
    @(negedge clk);
    drive(sel, st, rp, ad, cm);
  endtask

  // Compare {busy,done,env,out} every cycle until one cycle past done; optionally poke a new
  // request mid-frame or stop early at a given cycle.
  task automatic run_check(input int sel, input string tag, input int stop_at, input int poke_at,
                           output int busy_cnt, output int done_cnt);
    logic [3:0] obs, exp;
    logic [7:0] ad, cm;
    busy_cnt = 0;
    done_cnt = 0;
    ad = (sel != 0) ? b_addr : a_addr;
    cm = (sel != 0) ? b_cmd : a_cmd;
    for (int k = 0; k < m_len + 2; k++) begin
      @(negedge clk);
      if (k == stop_at) return;
      obs = (sel != 0) ? {b_busy, b_done, b_env, b_out} : {a_busy, a_done, a_env, a_out};
      exp = {k < m_len, k == m_len, (k < m_len) ? m_env[k] : 1'b0, (k < m_len) ? m_out[k] : 1'b0};
      chk($sformatf("%s_cyc%0d", tag, k), 32'(obs), 32'(exp));
      busy_cnt += int'(obs[3]);
      done_cnt += int'(obs[2]);
      if (k < m_len) cap[k] = obs[1];
      if (k == 0) drive(sel, 1'b0, 1'b0, ad, cm);
      if (k == poke_at) drive(sel, 1'b1, 1'b1, ~ad, ~cm);
      if (k == poke_at + 1) drive(sel, 1'b0, 1'b0, ~ad, ~cm);
    end
  endtask

  task automatic decode(input int u, output int lead_sp, output logic [31:0] w);
    int i, n;
    i = 0;
    w = '0;
    while (i < m_len && cap[i]) i++;
    n = 0;
    while (i < m_len && !cap[i]) begin n++; i++; end
    lead_sp = n;
    for (int b = 0; b < 32; b++) begin
      while (i < m_len && cap[i]) i++;
      n = 0;
      while (i < m_len && !cap[i]) begin n++; i++; end
      w[b] = (n > 2 * u);
    end
  endtask

  initial begin
    int bc, dc, lsp;
    logic [31:0] w;
    logic [7:0] ra, rc;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("reset_a", 32'({a_busy, a_done, a_env, a_out}), 32'd0);
    chk("reset_b", 32'({b_busy, b_done, b_env, b_out}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame addr=0x00 cmd=0xFF
    build(0, 1'b0, 8'h00, 8'hFF);
    launch(0, 1'b1, 1'b0, 8'h00, 8'hFF);
    run_check(0, "frame00ff", -1, -1, bc, dc);
    chk("frame00ff_busy_len", 32'(bc), 32'd484);
    chk("frame00ff_done_cnt", 32'(dc), 32'd1);

    // Repeat code
    build(0, 1'b1, 8'h00, 8'h00);
    launch(0, 1'b0, 1'b1, 8'h00, 8'h00);
    run_check(0, "repeat", -1, -1, bc, dc);
    chk("repeat_busy_len", 32'(bc), 32'd84);
    chk("repeat_done_cnt", 32'(dc), 32'd1);

    // start and repeat together: start wins
    build(0, 1'b0, 8'h59, 8'h16);
    launch(0, 1'b1, 1'b1, 8'h59, 8'h16);
    run_check(0, "both", -1, -1, bc, dc);
    decode(4, lsp, w);
    chk("both_lead_space", 32'(lsp), 32'd32);
    chk("both_byte0", 32'(w[7:0]), 32'h59);
    chk("both_byte1", 32'(w[15:8]), 32'hA6);
    chk("both_byte2", 32'(w[23:16]), 32'h16);
    chk("both_byte3", 32'(w[31:24]), 32'hE9);

    // Random frames with 8/2 timing: carrier phase restarts at each mark
    for (int t = 0; t < 2; t++) begin
      ra = 8'($urandom);
      rc = 8'($urandom);
      build(1, 1'b0, ra, rc);
      launch(1, 1'b1, 1'b0, ra, rc);
      run_check(1, $sformatf("rand_b%0d", t), -1, -1, bc, dc);
      chk("rand_b_busy_len", 32'(bc), 32'd968);
      chk("rand_b_done_cnt", 32'(dc), 32'd1);
    end
    build(1, 1'b1, 8'h00, 8'h00);
    launch(1, 1'b0, 1'b1, 8'h00, 8'h00);
    run_check(1, "repeat_b", -1, -1, bc, dc);
    chk("repeat_b_busy_len", 32'(bc), 32'd168);

    // Request and address change while busy are ignored
    ra = 8'($urandom);
    rc = 8'($urandom);
    build(0, 1'b0, ra, rc);
    launch(0, 1'b1, 1'b0, ra, rc);
    run_check(0, "busy_poke", -1, 150, bc, dc);
    chk("busy_poke_done_cnt", 32'(dc), 32'd1);
    repeat (2) @(negedge clk);
    chk("busy_poke_idle", 32'({a_busy, a_done, a_env, a_out}), 32'd0);

    // Reset during the first bit space aborts with no done pulse
    ra = 8'($urandom);
    rc = 8'($urandom);
    build(0, 1'b0, ra, rc);
    launch(0, 1'b1, 1'b0, ra, rc);
    run_check(0, "pre_rst", 102, -1, bc, dc);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({a_busy, a_done, a_env, a_out}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_outputs", 32'({a_busy, a_done, a_env, a_out}), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", 32'({a_busy, a_done, a_env, a_out}), 32'd0);
    ra = 8'($urandom);
    rc = 8'($urandom);
    build(0, 1'b0, ra, rc);
    launch(0, 1'b1, 1'b0, ra, rc);
    run_check(0, "post_rst", -1, -1, bc, dc);
    decode(4, lsp, w);
    chk("post_rst_word", w, {~rc, rc, ~ra, ra});
    chk("post_rst_done_cnt", 32'(dc), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
